// File: rtl/mem_initiator_if.sv
// Memory-side bus of the KV10 memory port: registered strobes/address/data out,
// read data and per-direction acknowledges back from memory.
interface mem_initiator_if #(
  parameter int PADDRSIZE = 22
) ();
  logic [PADDRSIZE-1:0] mem_addr;
  logic [35:0]          mem_write_data;
  logic                 mem_read;
  logic                 mem_write;
  logic [35:0]          mem_read_data;
  logic                 read_ack;
  logic                 write_ack;

  modport master (
    output mem_addr, mem_write_data, mem_read, mem_write,
    input  mem_read_data, read_ack, write_ack
  );

  modport slave (
    input  mem_addr, mem_write_data, mem_read, mem_write,
    output mem_read_data, read_ack, write_ack
  );
endinterface

// File: rtl/mem_initiator.sv
// Requester end of the KV10 memory port: turns single-cycle CPU read/write/RMW
// commands into held memory strobes, returns data, and aborts with NXM on timeout.
module mem_initiator #(
  parameter int PADDRSIZE = 22,
  parameter bit ACK_EARLY = 1'b0,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_read,
  input  logic                 cpu_write,
  input  logic                 cpu_rmw,
  input  logic [PADDRSIZE-1:0] cpu_addr,
  input  logic [35:0]          cpu_wdata,
  output logic [35:0]          cpu_rdata,
  output logic                 cpu_done,
  output logic                 cpu_nxm,
  output logic                 busy,
  mem_initiator_if.master      mem
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_CAP, WR_WAIT, RMW_HOLD} state_t;

  state_t               state, state_n;
  logic [PADDRSIZE-1:0] addr_q, addr_n;
  logic [35:0]          wdata_q, wdata_n;
  logic [35:0]          rdata_q, rdata_n;
  logic                 rd_q, rd_n;
  logic                 wr_q, wr_n;
  logic                 done_q, done_n;
  logic                 nxm_q, nxm_n;
  logic                 rmw_q, rmw_n;
  logic [CW-1:0]        cnt_q, cnt_n;
  logic                 capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      nxm_q   <= 1'b0;
      rmw_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      rdata_q <= rdata_n;
      rd_q    <= rd_n;
      wr_q    <= wr_n;
      done_q  <= done_n;
      nxm_q   <= nxm_n;
      rmw_q   <= rmw_n;
      cnt_q   <= cnt_n;
    end
  end

  // An ack is checked before the timeout, so an ack in the last wait cycle wins.
  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    rdata_n = rdata_q;
    rd_n    = rd_q;
    wr_n    = wr_q;
    done_n  = 1'b0;
    nxm_n   = 1'b0;
    rmw_n   = rmw_q;
    cnt_n   = cnt_q;
    capture = 1'b0;

    case (state)
      IDLE: begin
        if (cpu_rmw || cpu_read) begin
          addr_n  = cpu_addr;
          rd_n    = 1'b1;
          rmw_n   = cpu_rmw;
          cnt_n   = '0;
          state_n = RD_WAIT;
        end else if (cpu_write) begin
          addr_n  = cpu_addr;
          wdata_n = cpu_wdata;
          wr_n    = 1'b1;
          cnt_n   = '0;
          state_n = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem.read_ack) begin
          if (ACK_EARLY) state_n = RD_CAP;
          else capture = 1'b1;
        end else if (cnt_q == LAST_WAIT) begin
          rd_n    = 1'b0;
          nxm_n   = 1'b1;
          rmw_n   = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      RD_CAP: capture = 1'b1;
      RMW_HOLD: begin
        // The address latched by the read phase is reused for the write-back.
        if (cpu_write) begin
          wdata_n = cpu_wdata;
          wr_n    = 1'b1;
          cnt_n   = '0;
          state_n = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (mem.write_ack) begin
          wr_n    = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (cnt_q == LAST_WAIT) begin
          wr_n    = 1'b0;
          nxm_n   = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (capture) begin
      rdata_n = mem.mem_read_data;
      rd_n    = 1'b0;
      done_n  = 1'b1;
      rmw_n   = 1'b0;
      state_n = rmw_q ? RMW_HOLD : IDLE;
    end
  end

  assign mem.mem_addr       = addr_q;
  assign mem.mem_write_data = wdata_q;
  assign mem.mem_read       = rd_q;
  assign mem.mem_write      = wr_q;
  assign cpu_rdata          = rdata_q;
  assign cpu_done           = done_q;
  assign cpu_nxm            = nxm_q;
  assign busy               = (state != IDLE);

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: a registered-ack memory (ACK_EARLY=0) and a combinational-ack
// memory (ACK_EARLY=1), driven by a shared CPU command stream.
module tb_mem_initiator;
  localparam int PA = 22;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          cpu_read, cpu_write, cpu_rmw;
  logic [PA-1:0] cpu_addr;
  logic [35:0]   cpu_wdata;
  logic [35:0]   rdata0, rdata1;
  logic          done0, done1, nxm0, nxm1, busy0, busy1;

  mem_initiator_if #(.PADDRSIZE(PA)) mif0 ();
  mem_initiator_if #(.PADDRSIZE(PA)) mif1 ();

  mem_initiator #(.PADDRSIZE(PA), .ACK_EARLY(1'b0), .TIMEOUT(64)) dut0 (
    .clk(clk), .reset(reset), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_rmw(cpu_rmw),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata0), .cpu_done(done0),
    .cpu_nxm(nxm0), .busy(busy0), .mem(mif0)
  );

  mem_initiator #(.PADDRSIZE(PA), .ACK_EARLY(1'b1), .TIMEOUT(64)) dut1 (
    .clk(clk), .reset(reset), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_rmw(cpu_rmw),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata1), .cpu_done(done1),
    .cpu_nxm(nxm1), .busy(busy1), .mem(mif1)
  );

  // Memory 0: ack and data registered one cycle after the strobe; can be muted for manual acks.
  logic [35:0] ram0 [0:511];
  logic        auto_ack, man_rack, man_wack;
  logic [35:0] man_rdata, rdata0_q;
  logic        rack0_q, wack0_q;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 512; i++) ram0[i] <= '0;
      ram0[9'o100] <= 36'o123456701234;
      ram0[9'o300] <= 36'd5;
      ram0[9'o777] <= 36'o11;
      rack0_q  <= 1'b0;
      wack0_q  <= 1'b0;
      rdata0_q <= '0;
    end else begin
      rack0_q  <= mif0.mem_read;
      wack0_q  <= mif0.mem_write;
      rdata0_q <= ram0[mif0.mem_addr[8:0]];
      if (mif0.mem_write) ram0[mif0.mem_addr[8:0]] <= mif0.mem_write_data;
    end
  end

  assign mif0.read_ack      = auto_ack ? rack0_q  : man_rack;
  assign mif0.write_ack     = auto_ack ? wack0_q  : man_wack;
  assign mif0.mem_read_data = auto_ack ? rdata0_q : man_rdata;

  // Memory 1: combinational ack, read data registered so it is valid the cycle after the ack.
  logic [35:0] ram1 [0:511];
  logic [35:0] rdata1_q;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 512; i++) ram1[i] <= '0;
      ram1[9'o000] <= 36'o777;
      ram1[9'o500] <= 36'o1234;
      rdata1_q <= '0;
    end else begin
      rdata1_q <= ram1[mif1.mem_addr[8:0]];
      if (mif1.mem_write) ram1[mif1.mem_addr[8:0]] <= mif1.mem_write_data;
    end
  end

  assign mif1.read_ack      = mif1.mem_read;
  assign mif1.write_ack     = mif1.mem_write;
  assign mif1.mem_read_data = rdata1_q;

  int done_cnt0 = 0;
  int nxm_cnt0  = 0;
  always @(negedge clk) begin
    if (done0) done_cnt0++;
    if (nxm0)  nxm_cnt0++;
  end

  int checks = 0;
  int fails  = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 'o%0o, expected 'o%0o", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic rmw,
                               input logic [PA-1:0] addr, input logic [35:0] wd);
    cpu_read  = rd;
    cpu_write = wr;
    cpu_rmw   = rmw;
    cpu_addr  = addr;
    cpu_wdata = wd;
    tick();
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cpu_rmw   = 1'b0;
  endtask

  // Called in the cycle after the start; returns the cycle number of cpu_done/cpu_nxm.
  task automatic waitEnd0(output int cyc);
    cyc = 1;
    while (!done0 && !nxm0 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  typedef struct {
    logic          rd;
    logic          wr;
    logic [PA-1:0] addr;
    logic [35:0]   wdata;
    logic [35:0]   exp_rdata;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int d0;
    int n0;

    vecs[0] = '{1'b1, 1'b0, 22'o100, 36'o0,           36'o123456701234};
    vecs[1] = '{1'b0, 1'b1, 22'o200, 36'o777777000000, 36'o123456701234};
    vecs[2] = '{1'b1, 1'b0, 22'o200, 36'o0,           36'o777777000000};
    vecs[3] = '{1'b1, 1'b1, 22'o100, 36'o1,           36'o123456701234};
    vecs[4] = '{1'b1, 1'b0, 22'o100, 36'o0,           36'o123456701234};
    vecs[5] = '{1'b0, 1'b1, 22'o400, 36'o42,          36'o123456701234};
    vecs[6] = '{1'b1, 1'b0, 22'o400, 36'o0,           36'o42};

    reset = 1'b1;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_rmw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    auto_ack = 1'b1; man_rack = 1'b0; man_wack = 1'b0; man_rdata = '0;
    repeat (3) tick();
    checkOutput("reset busy", busy0, 1'b0);
    checkOutput("reset strobes", {mif0.mem_read, mif0.mem_write}, 2'b00);
    checkOutput("reset done/nxm", {done0, nxm0}, 2'b00);
    checkOutput("reset rdata", rdata0, 36'o0);
    reset = 1'b0;
    repeat (2) tick();

    $display("[TB] ACK_EARLY=1 read and write");
    applyStimulus(1'b1, 1'b0, 1'b0, 22'o500, 36'o0);
    checkOutput("early rd cyc1 ack", {mif1.mem_read, mif1.read_ack, done1}, 3'b110);
    tick();
    checkOutput("early rd cyc2 hold", {mif1.mem_read, busy1, done1}, 3'b110);
    checkOutput("early rd cyc2 rdata", rdata1, 36'o0);
    tick();
    checkOutput("early rd cyc3 done", {done1, mif1.mem_read}, 2'b10);
    checkOutput("early rd data", rdata1, 36'o1234);
    applyStimulus(1'b0, 1'b1, 1'b0, 22'o501, 36'o3);
    checkOutput("early wr strobe", mif1.mem_write, 1'b1);
    tick();
    checkOutput("early wr done", {done1, mif1.mem_write}, 2'b10);
    checkOutput("early wr ram", ram1[9'o501], 36'o3);
    repeat (3) tick();

    $display("[TB] vector table");
    for (int i = 0; i < 7; i++) begin
      d0 = done_cnt0;
      n0 = nxm_cnt0;
      applyStimulus(vecs[i].rd, vecs[i].wr, 1'b0, vecs[i].addr, vecs[i].wdata);
      checkOutput($sformatf("vec%0d strobe", i), {mif0.mem_read, mif0.mem_write},
                  vecs[i].rd ? 2'b10 : 2'b01);
      checkOutput($sformatf("vec%0d addr", i), mif0.mem_addr, vecs[i].addr);
      waitEnd0(cyc);
      checkOutput($sformatf("vec%0d latency", i), cyc, 3);
      checkOutput($sformatf("vec%0d rdata", i), rdata0, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d busy", i), busy0, 1'b0);
      repeat (3) tick();
      checkOutput($sformatf("vec%0d done count", i), done_cnt0 - d0, 1);
      checkOutput($sformatf("vec%0d nxm count", i), nxm_cnt0 - n0, 0);
    end

    $display("[TB] timeout and last-cycle ack");
    auto_ack = 1'b0;
    d0 = done_cnt0;
    applyStimulus(1'b1, 1'b0, 1'b0, 22'o100, 36'o0);
    repeat (63) tick();
    checkOutput("to wait64 strobe", {mif0.mem_read, nxm0, busy0}, 3'b101);
    tick();
    checkOutput("to nxm pulse", {nxm0, done0, mif0.mem_read, busy0}, 4'b1000);
    checkOutput("to rdata kept", rdata0, 36'o42);
    tick();
    checkOutput("to nxm width", nxm0, 1'b0);
    checkOutput("to no done", done_cnt0 - d0, 0);

    applyStimulus(1'b1, 1'b0, 1'b0, 22'o100, 36'o0);
    repeat (63) tick();
    man_rack  = 1'b1;
    man_rdata = 36'o555;
    tick();
    man_rack = 1'b0;
    checkOutput("late rd ack", {done0, nxm0}, 2'b10);
    checkOutput("late rd data", rdata0, 36'o555);
    tick();
    checkOutput("late rd no nxm", nxm0, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0, 22'o600, 36'o7);
    repeat (63) tick();
    man_wack = 1'b1;
    tick();
    man_wack = 1'b0;
    checkOutput("late wr ack", {done0, nxm0, mif0.mem_write}, 3'b100);
    tick();
    auto_ack = 1'b1;
    repeat (2) tick();

    $display("[TB] read-modify-write");
    n0 = nxm_cnt0;
    applyStimulus(1'b0, 1'b0, 1'b1, 22'o300, 36'o0);
    waitEnd0(cyc);
    checkOutput("rmw rd latency", cyc, 3);
    checkOutput("rmw rd data", rdata0, 36'd5);
    checkOutput("rmw hold busy", busy0, 1'b1);
    repeat (70) tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 22'o100, 36'o0);
    checkOutput("rmw hold idle", {busy0, mif0.mem_read, mif0.mem_write}, 3'b100);
    checkOutput("rmw hold no nxm", nxm_cnt0 - n0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 22'o777, 36'd6);
    checkOutput("rmw wr strobe", mif0.mem_write, 1'b1);
    checkOutput("rmw wr addr", mif0.mem_addr, 22'o300);
    checkOutput("rmw wr data", mif0.mem_write_data, 36'd6);
    waitEnd0(cyc);
    checkOutput("rmw wr latency", cyc, 3);
    checkOutput("rmw wr busy", busy0, 1'b0);
    checkOutput("rmw ram 300", ram0[9'o300], 36'd6);
    applyStimulus(1'b1, 1'b0, 1'b0, 22'o777, 36'o0);
    waitEnd0(cyc);
    checkOutput("rmw 777 untouched", rdata0, 36'o11);
    repeat (2) tick();

    $display("[TB] reset during write wait");
    auto_ack = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 22'o250, 36'o17);
    tick();
    checkOutput("rst pre strobe", mif0.mem_write, 1'b1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst async strobes", {mif0.mem_write, mif0.mem_read, busy0}, 3'b000);
    checkOutput("rst async addr", mif0.mem_addr, 22'o0);
    checkOutput("rst async wdata", mif0.mem_write_data, 36'o0);
    checkOutput("rst async rdata", rdata0, 36'o0);
    d0 = done_cnt0;
    n0 = nxm_cnt0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (70) tick();
    checkOutput("rst silent done", done_cnt0 - d0, 0);
    checkOutput("rst silent nxm", nxm_cnt0 - n0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
